// File: rtl/mem_access_unit.sv
// Purpose: memory-stage access unit; lw/sw/lb/sb to a word-wide RAM over a req/ack handshake.
// Latency: Done at k+2 cycles after Start for word/lb ops and 2k+3 for sb (k = Ack delay); faults finish in 1.
// Backpressure: Busy stalls the pipeline and Start is ignored until IDLE; a missing Ack aborts after TIMEOUT cycles.
module mem_access_unit #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          TIMEOUT   = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              MEM_WrEn,
  input  logic              ByteOp,
  input  logic [31:0]       ALU_MEM_Addr,
  input  logic [31:0]       MEM_DataIn,
  output logic [31:0]       MEM_out,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic              Ram_Req,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [31:0]       Ram_Wdata,
  input  logic [31:0]       Ram_Rdata,
  input  logic              Ram_Ack
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  localparam logic [32:0] RANGE_BYTES = 33'd4 << ADDR_W;
  localparam logic [7:0]  TO_LAST     = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q;
  logic        byte_q;
  logic [31:0] off;
  logic        fault;
  logic        accept;
  logic [31:0] merged;
  logic [7:0]  rd_byte;

  // Offset from the RAM window; wraps so addresses below the base land far out of range.
  assign off    = ALU_MEM_Addr - BASE_ADDR;
  assign fault  = ({1'b0, off} >= RANGE_BYTES) || (!ByteOp && (ALU_MEM_Addr[1:0] != 2'b00));
  assign accept = (state_q == IDLE) && Start;

  assign rd_byte = Ram_Rdata[{lane_q, 3'b000} +: 8];

  // Store byte is parked in Ram_Wdata[7:0] during RMW_RD, then spliced into the word just read.
  always_comb begin
    merged = Ram_Rdata;
    merged[{lane_q, 3'b000} +: 8] = Ram_Wdata[7:0];
  end

  // FSM state, error flag and Ack-wait counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, timeout counting and handshake outputs decoded from the state.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    Err     = 1'b0;
    Ram_Req = 1'b0;
    Ram_We  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          cnt_d = 8'd0;
          if (fault) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = !MEM_WrEn ? RD : (ByteOp ? RMW_RD : WR);
          end
        end
      end
      RD, WR, RMW_RD, RMW_WR: begin
        Busy    = 1'b1;
        Ram_Req = 1'b1;
        Ram_We  = (state_q == WR) || (state_q == RMW_WR);
        if (Ram_Ack) begin
          cnt_d   = 8'd0;
          state_d = (state_q == RMW_RD) ? RMW_WR : DONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = 8'd0;
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        Done    = 1'b1;
        Err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latching at accept, load result capture, and sb write-word assembly.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      MEM_out   <= 32'd0;
      Ram_Addr  <= '0;
      Ram_Wdata <= 32'd0;
      lane_q    <= 2'd0;
      byte_q    <= 1'b0;
    end else begin
      if (accept) begin
        Ram_Addr  <= off[ADDR_W+1:2];
        Ram_Wdata <= MEM_DataIn;
        lane_q    <= ALU_MEM_Addr[1:0];
        byte_q    <= ByteOp;
      end
      if ((state_q == RD) && Ram_Ack) begin
        MEM_out <= byte_q ? {24'd0, rd_byte} : Ram_Rdata;
      end
      if ((state_q == RMW_RD) && Ram_Ack) begin
        Ram_Wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: randomized bench for mem_access_unit with a RAM responder and a transaction-level model.
// Latency: expectations are derived per operation from Ack delays; outputs compared every cycle.
// Backpressure: Ack delay per phase is chosen by the stimulus; very long delays exercise the timeout.
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          TOUT = 255;
  localparam int          NEVER = 1000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        MEM_WrEn;
  logic        ByteOp;
  logic [31:0] ALU_MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic [31:0] MEM_out;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic        Ram_Req;
  logic        Ram_We;
  logic [9:0]  Ram_Addr;
  logic [31:0] Ram_Wdata;
  logic [31:0] Ram_Rdata;
  logic        Ram_Ack;

  mem_access_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MEM_WrEn(MEM_WrEn), .ByteOp(ByteOp),
    .ALU_MEM_Addr(ALU_MEM_Addr), .MEM_DataIn(MEM_DataIn), .MEM_out(MEM_out),
    .Busy(Busy), .Done(Done), .Err(Err), .Ram_Req(Ram_Req), .Ram_We(Ram_We),
    .Ram_Addr(Ram_Addr), .Ram_Wdata(Ram_Wdata), .Ram_Rdata(Ram_Rdata), .Ram_Ack(Ram_Ack)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [31:0] dev_mem [1024];
  logic [31:0] ref_mem [1024];

  // Expectations for the operation in flight (cycle numbers are absolute).
  bit          chk_en = 1'b0;
  int          op_p = -100, op_done = -50, req_lo = 1, req_hi = 0, we_lo = 1 << 30;
  bit          op_err = 1'b0;
  int          exp_addr = 0;
  logic [31:0] exp_wdata = 32'd0;
  logic [31:0] model_mo = 32'd0, mo_old = 32'd0, mo_new = 32'd0;
  int          k_rd_g = 1, k_wr_g = 1;

  // Observations.
  int done_seen = 0, last_done = 0, wr_cnt = 0, rd_cnt = 0, req_rises = 0;
  bit last_err = 1'b0;
  bit prev_req_n = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // RAM responder: acks each request k cycles after it starts; stray acks while idle.
  initial begin : responder
    int w;
    int kk;
    bit p_req;
    bit p_ack;
    w = 0; p_req = 1'b0; p_ack = 1'b0;
    Ram_Ack = 1'b0;
    Ram_Rdata = 32'd0;
    forever begin
      @(posedge Clk); #1;
      if (Ram_Req) begin
        if (!p_req || p_ack) w = 0;
        else w++;
      end
      kk = Ram_We ? k_wr_g : k_rd_g;
      if (Ram_Req) Ram_Ack = (w == kk);
      else         Ram_Ack = ($urandom_range(0, 7) == 0);
      Ram_Rdata = (Ram_Req && Ram_Ack) ? dev_mem[Ram_Addr] : $urandom;
      p_req = Ram_Req;
      p_ack = Ram_Ack;
    end
  end

  // Per-cycle compare against the operation-level expectations; RAM writes land here.
  always @(negedge Clk) begin
    bit e_done, e_busy, e_req, e_we;
    if (chk_en) begin
      e_done = (cyc == op_done);
      e_busy = (cyc > op_p) && (cyc < op_done);
      e_req  = (cyc >= req_lo) && (cyc <= req_hi);
      e_we   = e_req && (cyc >= we_lo);
      chk("done", {31'd0, Done}, {31'd0, e_done});
      chk("busy", {31'd0, Busy}, {31'd0, e_busy});
      chk("err", {31'd0, Err}, {31'd0, e_done && op_err});
      chk("req", {31'd0, Ram_Req}, {31'd0, e_req});
      chk("we", {31'd0, Ram_We}, {31'd0, e_we});
      chk("mem_out", MEM_out, (cyc >= op_done) ? mo_new : mo_old);
      if (e_req && Ram_Req) chk("ram_addr", {22'd0, Ram_Addr}, exp_addr);
      if (Ram_Req && Ram_Ack && Ram_We) chk("wdata", Ram_Wdata, exp_wdata);
    end
    if (Done) begin
      done_seen++;
      last_done = cyc;
      last_err  = Err;
    end
    if (Ram_Req && !prev_req_n) req_rises++;
    prev_req_n = Ram_Req;
    if (Ram_Req && Ram_Ack) begin
      if (Ram_We) begin
        dev_mem[Ram_Addr] = Ram_Wdata;
        wr_cnt++;
      end else begin
        rd_cnt++;
      end
    end
  end

  // Issue one op in the current cycle and return on the cycle after its Done.
  // junk: 1 = extra Start while busy, 2 = extra Start in the Done cycle.
  task automatic do_op(input bit wr, input bit bop, input logic [31:0] addr,
                       input logic [31:0] din, input int krd, input int kwr, input int junk);
    logic [31:0] off;
    int p, w, lane, wr0;
    bit flt, exp_wr;
    p = cyc;
    off = addr - BASE;
    w = int'(off >> 2) & 1023;
    lane = int'(addr[1:0]);
    flt = (off >= 32'd4096) || (!bop && addr[1:0] != 2'b00);
    mo_old = model_mo;
    exp_wr = 1'b0;
    op_err = 1'b0;
    we_lo = 1 << 30;
    exp_addr = w;
    req_lo = p + 1;
    if (flt) begin
      req_hi = p; op_done = p + 1; op_err = 1'b1;
    end else if (!wr) begin
      if (krd >= TOUT) begin
        req_hi = p + TOUT; op_done = p + TOUT + 1; op_err = 1'b1;
      end else begin
        req_hi = p + 1 + krd; op_done = p + krd + 2;
        model_mo = bop ? ((ref_mem[w] >> (8 * lane)) & 32'hFF) : ref_mem[w];
      end
    end else if (!bop) begin
      we_lo = p + 1;
      if (kwr >= TOUT) begin
        req_hi = p + TOUT; op_done = p + TOUT + 1; op_err = 1'b1;
      end else begin
        req_hi = p + 1 + kwr; op_done = p + kwr + 2;
        exp_wdata = din; ref_mem[w] = din; exp_wr = 1'b1;
      end
    end else begin
      if (krd >= TOUT) begin
        req_hi = p + TOUT; op_done = p + TOUT + 1; op_err = 1'b1;
      end else begin
        we_lo = p + krd + 2;
        if (kwr >= TOUT) begin
          req_hi = p + krd + 1 + TOUT; op_done = p + krd + 2 + TOUT; op_err = 1'b1;
        end else begin
          req_hi = p + krd + kwr + 2; op_done = p + krd + kwr + 3;
          exp_wdata = (ref_mem[w] & ~(32'hFF << (8 * lane))) | ({24'd0, din[7:0]} << (8 * lane));
          ref_mem[w] = exp_wdata; exp_wr = 1'b1;
        end
      end
    end
    mo_new = model_mo;
    op_p = p;
    k_rd_g = krd;
    k_wr_g = kwr;
    wr0 = wr_cnt;
    Start = 1'b1; MEM_WrEn = wr; ByteOp = bop; ALU_MEM_Addr = addr; MEM_DataIn = din;
    @(posedge Clk); #1;
    Start = 1'b0; MEM_WrEn = $urandom_range(0, 1); ByteOp = $urandom_range(0, 1);
    ALU_MEM_Addr = BASE + $urandom_range(0, 4095); MEM_DataIn = $urandom;
    if (junk == 1 && op_done > p + 4) begin
      while (cyc < p + 3) begin @(posedge Clk); #1; end
      Start = 1'b1; ALU_MEM_Addr = BASE + 32'd8; MEM_WrEn = 1'b1; ByteOp = 1'b0;
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    while (cyc < op_done) begin @(posedge Clk); #1; end
    if (junk == 2) begin
      Start = 1'b1; ALU_MEM_Addr = BASE + 32'd12; MEM_WrEn = 1'b1; ByteOp = 1'b1;
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("wr_count", wr_cnt - wr0, {31'd0, exp_wr});
  endtask

  function automatic logic [31:0] rand_addr(input bit bop);
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 11);
    if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 16)) + 32'($urandom_range(0, 3));
    else if (r == 1) a = BASE + 32'd4096 + 32'($urandom_range(0, 2000));
    else if (r == 2) a = $urandom;
    else begin
      a = BASE + 32'(4 * ((r < 8) ? $urandom_range(0, 15) : $urandom_range(0, 1023)));
      if (bop || $urandom_range(0, 7) == 0) a = a + 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  initial begin : stim
    int p0, d0, w0, r0, q0, mism;
    bit wr, bop;
    int krd, kwr, junk;
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    Reset = 1'b0; Start = 1'b0; MEM_WrEn = 1'b0; ByteOp = 1'b0;
    ALU_MEM_Addr = 32'd0; MEM_DataIn = 32'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_mem_out", MEM_out, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_req", {31'd0, Ram_Req}, 32'd0);
    chk("rst_addr", {22'd0, Ram_Addr}, 32'd0);
    chk("rst_wdata", Ram_Wdata, 32'd0);
    #2 Reset = 1'b1;
    @(posedge Clk); #1;
    chk_en = 1'b1;

    // Hand-computed cases pinning the model.
    dev_mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
    dev_mem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;
    p0 = cyc; d0 = done_seen;
    do_op(1'b0, 1'b0, 32'h400, 32'h0, 1, 1, 0);
    chk("lit_lw_out", MEM_out, 32'hDEADBEEF);
    chk("lit_lw_lat", last_done - p0, 3);
    chk("lit_lw_pulses", done_seen - d0, 1);
    chk("lit_lw_err", {31'd0, last_err}, 32'd0);

    p0 = cyc;
    do_op(1'b0, 1'b1, 32'h406, 32'h0, 2, 2, 0);
    chk("lit_lb_out", MEM_out, 32'h00000022);
    chk("lit_lb_lat", last_done - p0, 4);

    p0 = cyc; r0 = rd_cnt; w0 = wr_cnt;
    do_op(1'b1, 1'b1, 32'h405, 32'h000000AB, 1, 1, 2);
    chk("lit_sb_ram", dev_mem[1], 32'h1122AB44);
    chk("lit_sb_out", MEM_out, 32'h00000022);
    chk("lit_sb_reads", rd_cnt - r0, 1);
    chk("lit_sb_writes", wr_cnt - w0, 1);
    chk("lit_sb_lat", last_done - p0, 5);

    p0 = cyc; q0 = req_rises;
    do_op(1'b1, 1'b0, 32'h402, 32'h12345678, 1, 1, 0);
    chk("lit_mis_lat", last_done - p0, 1);
    chk("lit_mis_err", {31'd0, last_err}, 32'd1);
    p0 = cyc;
    do_op(1'b0, 1'b0, 32'h3FC, 32'h0, 1, 1, 0);
    chk("lit_low_lat", last_done - p0, 1);
    chk("lit_low_err", {31'd0, last_err}, 32'd1);
    chk("lit_no_req", req_rises - q0, 0);

    p0 = cyc;
    do_op(1'b0, 1'b0, 32'h400, 32'h0, NEVER, NEVER, 1);
    chk("lit_to_lat", last_done - p0, 256);
    chk("lit_to_err", {31'd0, last_err}, 32'd1);
    p0 = cyc;
    do_op(1'b0, 1'b0, 32'h404, 32'h0, 254, 1, 0);
    chk("lit_late_ack_lat", last_done - p0, 256);
    chk("lit_late_ack_err", {31'd0, last_err}, 32'd0);
    chk("lit_late_ack_out", MEM_out, 32'h1122AB44);

    // Reset in the middle of the read phase of an sb.
    chk_en = 1'b0;
    w0 = wr_cnt; d0 = done_seen;
    k_rd_g = NEVER; k_wr_g = 1;
    Start = 1'b1; MEM_WrEn = 1'b1; ByteOp = 1'b1; ALU_MEM_Addr = 32'h409; MEM_DataIn = 32'h55;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("mid_req_up", {31'd0, Ram_Req}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, Ram_Req}, 32'd0);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_out", MEM_out, 32'd0);
    chk("mid_rst_we", {31'd0, Ram_We}, 32'd0);
    chk("mid_rst_addr", {22'd0, Ram_Addr}, 32'd0);
    repeat (3) @(posedge Clk);
    #3 Reset = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("mid_rst_nowrite", wr_cnt - w0, 0);
    chk("mid_rst_nodone", done_seen - d0, 0);
    model_mo = 32'd0; mo_old = 32'd0; mo_new = 32'd0;
    op_p = cyc - 100; op_done = cyc - 50; req_lo = 1; req_hi = 0;
    chk_en = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 160; n++) begin
      wr  = 1'($urandom_range(0, 1));
      bop = 1'($urandom_range(0, 1));
      krd = ($urandom_range(0, 39) == 0) ? NEVER : $urandom_range(0, 4);
      kwr = ($urandom_range(0, 39) == 0) ? NEVER : $urandom_range(0, 4);
      junk = $urandom_range(0, 5);
      if (junk > 2) junk = 0;
      do_op(wr, bop, rand_addr(bop), $urandom, krd, kwr, junk);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (dev_mem[i] !== ref_mem[i]) mism++;
    chk("final_mem", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
